// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the alarm controller and the rest of the clock:
// timing strobes, buttons, current time in, alarm digits and buzzer out.
interface alarm_ctrl_if;
    logic       en1hz;
    logic       sig2hz;
    logic       set;
    logic       adj;
    logic       arm;
    logic       stop;
    logic       snooze;
    logic [3:0] hour_upper;
    logic [3:0] hour_lower;
    logic [3:0] min_upper;
    logic [3:0] min_lower;
    logic [3:0] sec_upper;
    logic [3:0] sec_lower;
    logic [3:0] al_hour_upper;
    logic [3:0] al_hour_lower;
    logic [3:0] al_min_upper;
    logic [3:0] al_min_lower;
    logic       al_hon;
    logic       al_mon;
    logic       armed;
    logic       editing;
    logic       buzzer;

    modport master (
        output en1hz, sig2hz, set, adj, arm, stop, snooze,
        output hour_upper, hour_lower, min_upper, min_lower, sec_upper, sec_lower,
        input  al_hour_upper, al_hour_lower, al_min_upper, al_min_lower,
        input  al_hon, al_mon, armed, editing, buzzer
    );

    modport slave (
        input  en1hz, sig2hz, set, adj, arm, stop, snooze,
        input  hour_upper, hour_lower, min_upper, min_lower, sec_upper, sec_lower,
        output al_hour_upper, al_hour_lower, al_min_upper, al_min_lower,
        output al_hon, al_mon, armed, editing, buzzer
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD alarm time editing, time match detection and
// buzzer sequencing through ring, snooze and auto-stop phases.
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic         clk,
    input  logic         rst,
    alarm_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, EDIT_HOUR, EDIT_MIN, ARMED, RING, SNOOZE
    } state_t;

    localparam logic [7:0]  RING_LAST   = 8'(RING_SEC - 1);
    localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);

    state_t      state_q, state_d;
    logic [7:0]  al_hour_q, al_hour_d;
    logic [7:0]  al_min_q, al_min_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic [11:0] snz_cnt_q, snz_cnt_d;
    logic        match, match_q;
    logic        buzzer_q, buzzer_d;
    logic        trigger;
    logic [7:0]  hour_inc, min_inc;

    assign match = ({bus.hour_upper, bus.hour_lower} == al_hour_q) &&
                   ({bus.min_upper, bus.min_lower} == al_min_q) &&
                   (bus.sec_upper == 4'd0) && (bus.sec_lower == 4'd0);

    // Rising edge of match only, so arming inside the matching second never rings.
    assign trigger = match && !match_q && (state_q == ARMED);

    always_comb begin
        if (al_hour_q == 8'h23)
            hour_inc = 8'h00;
        else if (al_hour_q[3:0] == 4'd9)
            hour_inc = {al_hour_q[7:4] + 4'd1, 4'd0};
        else
            hour_inc = {al_hour_q[7:4], al_hour_q[3:0] + 4'd1};

        if (al_min_q[3:0] != 4'd9)
            min_inc = {al_min_q[7:4], al_min_q[3:0] + 4'd1};
        else if (al_min_q[7:4] == 4'd5)
            min_inc = 8'h00;
        else
            min_inc = {al_min_q[7:4] + 4'd1, 4'd0};
    end

    always_comb begin
        state_d    = state_q;
        al_hour_d  = al_hour_q;
        al_min_d   = al_min_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        buzzer_d   = (state_q == RING) && bus.sig2hz;

        case (state_q)
            IDLE: begin
                if (bus.set)
                    state_d = EDIT_HOUR;
                else if (bus.arm)
                    state_d = ARMED;
            end
            EDIT_HOUR: begin
                if (bus.set)
                    state_d = EDIT_MIN;
                else if (bus.adj)
                    al_hour_d = hour_inc;
            end
            EDIT_MIN: begin
                if (bus.set)
                    state_d = IDLE;
                else if (bus.adj)
                    al_min_d = min_inc;
            end
            ARMED: begin
                if (bus.arm) begin
                    state_d = IDLE;
                end else if (trigger) begin
                    state_d    = RING;
                    ring_cnt_d = 8'd0;
                end
            end
            RING: begin
                if (bus.arm) begin
                    state_d = IDLE;
                end else if (bus.stop) begin
                    state_d = ARMED;
                end else if (bus.snooze) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = SNOOZE_LOAD;
                end else if (bus.en1hz) begin
                    if (ring_cnt_q == RING_LAST)
                        state_d = ARMED;
                    else
                        ring_cnt_d = ring_cnt_q + 8'd1;
                end
            end
            SNOOZE: begin
                if (bus.arm) begin
                    state_d = IDLE;
                end else if (bus.stop) begin
                    state_d = ARMED;
                end else if (bus.en1hz) begin
                    snz_cnt_d = snz_cnt_q - 12'd1;
                    if (snz_cnt_q == 12'd1) begin
                        state_d    = RING;
                        ring_cnt_d = 8'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            al_hour_q  <= 8'h00;
            al_min_q   <= 8'h00;
            ring_cnt_q <= 8'd0;
            snz_cnt_q  <= 12'd0;
            match_q    <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            al_hour_q  <= al_hour_d;
            al_min_q   <= al_min_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            match_q    <= match;
            buzzer_q   <= buzzer_d;
        end
    end

    assign bus.al_hour_upper = al_hour_q[7:4];
    assign bus.al_hour_lower = al_hour_q[3:0];
    assign bus.al_min_upper  = al_min_q[7:4];
    assign bus.al_min_lower  = al_min_q[3:0];
    assign bus.al_hon        = !((state_q == EDIT_HOUR) && !bus.sig2hz);
    assign bus.al_mon        = !((state_q == EDIT_MIN) && !bus.sig2hz);
    assign bus.armed         = (state_q == ARMED) || (state_q == RING) || (state_q == SNOOZE);
    assign bus.editing       = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN);
    assign bus.buzzer        = buzzer_q;
endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: editing, wraparound, ring/snooze timing,
// button priorities and reset behaviour, checked with immediate assertions.
module tb_alarm_ctrl;
    localparam logic [4:0] SET = 5'b10000;
    localparam logic [4:0] ADJ = 5'b01000;
    localparam logic [4:0] ARM = 5'b00100;
    localparam logic [4:0] STP = 5'b00010;
    localparam logic [4:0] SNZ = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alarm_ctrl_if bus ();

    alarm_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic [4:0] b);
        {bus.set, bus.adj, bus.arm, bus.stop, bus.snooze} = b;
        step();
        {bus.set, bus.adj, bus.arm, bus.stop, bus.snooze} = 5'b0;
    endtask

    task automatic press_n(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        {bus.hour_upper, bus.hour_lower} = h;
        {bus.min_upper, bus.min_lower}   = m;
        {bus.sec_upper, bus.sec_lower}   = s;
    endtask

    function automatic logic [15:0] alarm_time();
        return {bus.al_hour_upper, bus.al_hour_lower, bus.al_min_upper, bus.al_min_lower};
    endfunction

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        {bus.set, bus.adj, bus.arm, bus.stop, bus.snooze} = 5'b0;
        bus.en1hz  = 1'b0;
        bus.sig2hz = 1'b0;
        set_time(8'h12, 8'h34, 8'h56);

        // Reset values
        steps(2);
        check_output("rst_alarm",   alarm_time(), 16'h0000);
        check_output("rst_armed",   16'(bus.armed), 16'd0);
        check_output("rst_editing", 16'(bus.editing), 16'd0);
        check_output("rst_hon",     16'(bus.al_hon), 16'd1);
        check_output("rst_mon",     16'(bus.al_mon), 16'd1);
        check_output("rst_buzzer",  16'(bus.buzzer), 16'd0);
        rst = 1'b1;
        step();

        // Edit alarm to 07:30
        press(SET);
        check_output("eh_editing", 16'(bus.editing), 16'd1);
        check_output("eh_armed",   16'(bus.armed), 16'd0);
        check_output("eh_hon_low", 16'(bus.al_hon), 16'd0);
        check_output("eh_mon",     16'(bus.al_mon), 16'd1);
        bus.sig2hz = 1'b1;
        #1;
        check_output("eh_hon_high", 16'(bus.al_hon), 16'd1);
        bus.sig2hz = 1'b0;
        press_n(ADJ, 7);
        check_output("hour_07", alarm_time(), 16'h0700);
        press(SET);
        check_output("em_editing", 16'(bus.editing), 16'd1);
        check_output("em_mon_low", 16'(bus.al_mon), 16'd0);
        check_output("em_hon",     16'(bus.al_hon), 16'd1);
        press_n(ADJ, 30);
        check_output("alarm_0730", alarm_time(), 16'h0730);
        press(SET);
        check_output("idle_editing", 16'(bus.editing), 16'd0);
        check_output("idle_mon",     16'(bus.al_mon), 16'd1);
        check_output("idle_armed",   16'(bus.armed), 16'd0);

        // Wraparound and set-over-adj priority
        press(SET);
        press_n(ADJ, 16);
        check_output("hour_23", alarm_time(), 16'h2330);
        press(ADJ);
        check_output("hour_wrap", alarm_time(), 16'h0030);
        press(SET | ADJ);
        check_output("set_adj_digit", alarm_time(), 16'h0030);
        check_output("set_adj_state", 16'(bus.al_mon), 16'd0);
        press_n(ADJ, 29);
        check_output("min_59", alarm_time(), 16'h0059);
        press(ADJ);
        check_output("min_wrap", alarm_time(), 16'h0000);
        press(SET);
        press(SET);
        press_n(ADJ, 7);
        press(SET);
        press_n(ADJ, 30);
        press(SET);
        check_output("reedit_0730", alarm_time(), 16'h0730);

        // Arm and trigger, buzzer lag, auto-stop after 60 seconds
        set_time(8'h07, 8'h29, 8'h59);
        press(ARM);
        check_output("arm_armed", 16'(bus.armed), 16'd1);
        bus.sig2hz = 1'b1;
        set_time(8'h07, 8'h30, 8'h00);
        step();
        check_output("trig_buz_lag", 16'(bus.buzzer), 16'd0);
        step();
        check_output("ring_buz_1", 16'(bus.buzzer), 16'd1);
        bus.sig2hz = 1'b0;
        step();
        check_output("ring_buz_0", 16'(bus.buzzer), 16'd0);
        bus.sig2hz = 1'b1;
        step();
        check_output("ring_buz_1b", 16'(bus.buzzer), 16'd1);
        bus.en1hz = 1'b1;
        steps(59);
        bus.en1hz = 1'b0;
        step();
        check_output("ring_59_still", 16'(bus.buzzer), 16'd1);
        bus.en1hz = 1'b1;
        step();
        bus.en1hz = 1'b0;
        step();
        check_output("ring_60_stop", 16'(bus.buzzer), 16'd0);
        check_output("ring_60_armed", 16'(bus.armed), 16'd1);
        steps(3);
        check_output("no_retrigger", 16'(bus.buzzer), 16'd0);

        // Snooze for 300 seconds, back to RING, stop
        set_time(8'h07, 8'h30, 8'h01);
        step();
        set_time(8'h07, 8'h30, 8'h00);
        step();
        step();
        check_output("ring2_buz", 16'(bus.buzzer), 16'd1);
        press(SNZ);
        step();
        check_output("snz_buz", 16'(bus.buzzer), 16'd0);
        check_output("snz_armed", 16'(bus.armed), 16'd1);
        bus.en1hz = 1'b1;
        steps(299);
        bus.en1hz = 1'b0;
        step();
        check_output("snz_299_quiet", 16'(bus.buzzer), 16'd0);
        bus.en1hz = 1'b1;
        step();
        bus.en1hz = 1'b0;
        step();
        check_output("snz_300_ring", 16'(bus.buzzer), 16'd1);
        press(STP);
        step();
        check_output("stop_buz", 16'(bus.buzzer), 16'd0);
        check_output("stop_armed", 16'(bus.armed), 16'd1);

        // arm during SNOOZE disarms
        set_time(8'h07, 8'h30, 8'h01);
        step();
        set_time(8'h07, 8'h30, 8'h00);
        step();
        press(SNZ);
        press(ARM);
        check_output("snz_arm_armed", 16'(bus.armed), 16'd0);
        step();
        check_output("snz_arm_buz", 16'(bus.buzzer), 16'd0);

        // Arming inside the matching second does not ring
        press(ARM);
        steps(3);
        check_output("late_arm_armed", 16'(bus.armed), 16'd1);
        check_output("late_arm_buz",   16'(bus.buzzer), 16'd0);

        // arm+stop together in RING -> IDLE
        set_time(8'h07, 8'h30, 8'h01);
        step();
        set_time(8'h07, 8'h30, 8'h00);
        step();
        step();
        check_output("ring3_buz", 16'(bus.buzzer), 16'd1);
        press(ARM | STP);
        check_output("arm_stop_armed", 16'(bus.armed), 16'd0);
        step();
        check_output("arm_stop_buz", 16'(bus.buzzer), 16'd0);

        // Reset while ringing
        set_time(8'h07, 8'h30, 8'h01);
        press(ARM);
        set_time(8'h07, 8'h30, 8'h00);
        step();
        step();
        check_output("ring4_buz", 16'(bus.buzzer), 16'd1);
        rst = 1'b0;
        step();
        check_output("rst_ring_buz",     16'(bus.buzzer), 16'd0);
        check_output("rst_ring_alarm",   alarm_time(), 16'h0000);
        check_output("rst_ring_armed",   16'(bus.armed), 16'd0);
        check_output("rst_ring_editing", 16'(bus.editing), 16'd0);
        rst = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
